// File: rtl/proc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// proc_pkg : launcher state encoding, PC width and default program addresses
// Revision : 1.0
// ---------------------------------------------------------------------------
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } launch_state_t;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  localparam logic [PC_W-1:0] DEF_PROG0_START = 10'd0;
  localparam logic [PC_W-1:0] DEF_PROG1_START = 10'd20;
  localparam logic [PC_W-1:0] DEF_PROG2_START = 10'd40;
  localparam logic [PC_W-1:0] DEF_PROG3_START = 10'd60;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : up-counter with synchronous clear/enable, sticks at all-ones
// Revision    : 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] count_q;

  // next_o is the value the counter takes if enabled this cycle
  assign next_o  = (&count_q) ? count_q : count_q + 1'b1;
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= next_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_launcher.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prog_launcher : freezes fetch, forces a jump to a program start, runs it
//                 until Halt or watchdog, counting execution cycles
// Revision      : 1.0
// ---------------------------------------------------------------------------
module prog_launcher
  import proc_pkg::*;
#(
  parameter int               NUM_PROGS   = 3,
  parameter logic [PC_W-1:0]  PROG0_START = DEF_PROG0_START,
  parameter logic [PC_W-1:0]  PROG1_START = DEF_PROG1_START,
  parameter logic [PC_W-1:0]  PROG2_START = DEF_PROG2_START,
  parameter logic [PC_W-1:0]  PROG3_START = DEF_PROG3_START,
  parameter logic [CNT_W-1:0] TIMEOUT     = 16'd4000
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Prog_sel,
  input  logic             Halt,
  output logic             Init,
  output logic [1:0]       ProgState,
  output logic             Jump_en,
  output logic             Jump_flag,
  output logic [PC_W-1:0]  Jump_target,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic             Sel_err,
  output logic [CNT_W-1:0] Cycles
);

  launch_state_t    state_q, state_d;
  logic [1:0]       prog_q, prog_d;
  logic             timeout_q, timeout_d;
  logic             sel_err_q, sel_err_d;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_sel_valid;
  logic [CNT_W-1:0] w_cnt_next;
  logic [PC_W-1:0]  w_start_pc;

  assign w_sel_valid = (int'(Prog_sel) < NUM_PROGS);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      prog_q    <= 2'd0;
      timeout_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prog_q    <= prog_d;
      timeout_q <= timeout_d;
      sel_err_q <= sel_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prog_d    = prog_q;
    timeout_d = timeout_q;
    sel_err_d = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          if (w_sel_valid) begin
            prog_d    = Prog_sel;
            timeout_d = 1'b0;
            w_cnt_clr = 1'b1;
            state_d   = LOAD;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // the halting cycle is itself counted; Halt outranks the watchdog
        w_cnt_en = 1'b1;
        if (Halt) begin
          state_d = DONE;
        end else if (w_cnt_next == TIMEOUT) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_start_pc = PROG0_START;
    case (prog_q)
      2'd0: w_start_pc = PROG0_START;
      2'd1: w_start_pc = PROG1_START;
      2'd2: w_start_pc = PROG2_START;
      2'd3: w_start_pc = PROG3_START;
      default: w_start_pc = PROG0_START;
    endcase
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .clr_i   (w_cnt_clr),
    .en_i    (w_cnt_en),
    .count_o (Cycles),
    .next_o  (w_cnt_next)
  );

  // outputs decode only flops, so there is no input-to-output path
  assign Init        = (state_q == IDLE) || (state_q == DONE);
  assign Busy        = (state_q == LOAD) || (state_q == RUN);
  assign Done        = (state_q == DONE);
  assign Jump_en     = (state_q == LOAD);
  assign Jump_flag   = (state_q == LOAD);
  assign Jump_target = (state_q == LOAD) ? w_start_pc : '0;
  assign ProgState   = prog_q;
  assign Timeout     = timeout_q;
  assign Sel_err     = sel_err_q;

endmodule
`default_nettype wire
